// File: rtl/noc_cfg_sequencer_pkg.sv
// noc_cfg_sequencer_pkg: shared configure-word layout, FSM encodings and request entry type
package noc_cfg_sequencer_pkg;
  localparam int CFG_W = 11;
  localparam int NODE_W = 2;
  localparam int TAG_W = 7;
  localparam int CFG_SEND = 9;
  localparam int CFG_TAG_LSB = 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_NODE,
    S_ISSUE,
    S_GAP,
    S_DRAIN
  } seq_state_t;
  typedef struct packed {
    logic [NODE_W-1:0] dest;
    logic [TAG_W-1:0] tag;
  } cfg_req_t;
  function automatic logic [CFG_W-1:0] cfg_word(input cfg_req_t r);
    logic [CFG_W-1:0] w;
    w = '0;
    w[CFG_SEND] = 1'b1;
    w[CFG_TAG_LSB +: TAG_W] = r.tag;
    w[NODE_W-1:0] = r.dest;
    return w;
  endfunction
endpackage

// File: rtl/noc_cfg_fifo.sv
// noc_cfg_fifo: request queue of {dest,tag} entries
//   clock/reset (async, active-low), push/push_data, pop, head (oldest entry), count.
//   Push while full and pop while empty are ignored; DEPTH must be a power of two.
module noc_cfg_fifo
  import noc_cfg_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  cfg_req_t                 push_data,
  input  logic                     pop,
  output cfg_req_t                 head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  cfg_req_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic wr, rd;
  assign wr = push && count != CW'(DEPTH);
  assign rd = pop && count != '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= push_data;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      count <= count + CW'(wr) - CW'(rd);
    end
endmodule

// File: rtl/noc_cfg_sequencer.sv
// noc_cfg_sequencer: queues processor requests and issues them as mesh configure words with timeout/retry/drop
//   clock/reset (async, active-low); req_valid/req_ready/req_dest/req_tag request side;
//   node_ready mesh handshake in; configure word out; busy, done_pulse, error_pulse,
//   error_dest (sticky dest of last drop), fifo_count.
module noc_cfg_sequencer
  import noc_cfg_sequencer_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_RETRY = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [NODE_W-1:0]             req_dest,
  input  logic [TAG_W-1:0]              req_tag,
  input  logic                          node_ready,
  output logic [CFG_W-1:0]              configure,
  output logic                          busy,
  output logic                          done_pulse,
  output logic                          error_pulse,
  output logic [NODE_W-1:0]             error_dest,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 1);
  seq_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic gap_q, gap_d;
  logic [CFG_W-1:0] cfg_d;
  logic done_d, err_d;
  logic [NODE_W-1:0] err_dest_d;
  logic push, pop, empty;
  cfg_req_t head;
  // req_ready depends on the count alone, so a same-cycle pop never frees a slot for a push
  assign req_ready = fifo_count != CW'(FIFO_DEPTH);
  assign push = req_valid && req_ready;
  assign empty = fifo_count == '0;
  assign busy = state_q != S_IDLE || !empty;
  noc_cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data ('{dest: req_dest, tag: req_tag}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      retry_q <= '0;
      gap_q <= 1'b0;
      configure <= '0;
      done_pulse <= 1'b0;
      error_pulse <= 1'b0;
      error_dest <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      gap_q <= gap_d;
      configure <= cfg_d;
      done_pulse <= done_d;
      error_pulse <= err_d;
      error_dest <= err_dest_d;
    end
  // configure is registered and only non-zero while in ISSUE; every exit from ISSUE clears it
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    gap_d = gap_q;
    cfg_d = configure;
    done_d = 1'b0;
    err_d = 1'b0;
    err_dest_d = error_dest;
    pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cfg_d = '0;
        if (!empty) begin
          if (head.dest == NODE_W'(NODE_ID)) begin
            pop = 1'b1;
            err_d = 1'b1;
            err_dest_d = head.dest;
          end else state_d = S_WAIT_NODE;
        end
      end
      S_WAIT_NODE: begin
        cfg_d = '0;
        if (node_ready) begin
          cfg_d = cfg_word(head);
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!node_ready) begin
          pop = 1'b1;
          retry_d = '0;
          cfg_d = '0;
          state_d = S_DRAIN;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          retry_d = retry_q + 1'b1;
          cfg_d = '0;
          gap_d = 1'b0;
          state_d = S_GAP;
        end else timer_d = timer_q + 1'b1;
      end
      S_GAP: begin
        cfg_d = '0;
        if (!gap_q) gap_d = 1'b1;
        else if (retry_q == RW'(MAX_RETRY)) begin
          pop = 1'b1;
          err_d = 1'b1;
          err_dest_d = head.dest;
          retry_d = '0;
          state_d = S_IDLE;
        end else state_d = S_WAIT_NODE;
      end
      S_DRAIN: begin
        cfg_d = '0;
        if (node_ready) begin
          done_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        cfg_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end
endmodule
